// File: rtl/viterbi_pkg.sv
// Shared definitions for the frame-based K=3 rate-1/2 Viterbi decoder:
// FSM encoding, code generators, parameter defaults and trellis helpers.
package viterbi_pkg;

  localparam int NSYM_DEF    = 4;
  localparam int PM_W_DEF    = 5;
  localparam int PM_INIT_DEF = 16;

  // Generator taps over {u, s1, s0}.
  localparam logic [2:0] G_ODD  = 3'b111;
  localparam logic [2:0] G_EVEN = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACS  = 2'd1,
    ST_TB   = 2'd2,
    ST_OUT  = 2'd3
  } state_e;

  // Encoder output {odd, even} for input bit u leaving state s = {s1, s0}.
  function automatic logic [1:0] branch_out(input logic u, input logic [1:0] s);
    logic [2:0] taps;
    taps = {u, s};
    return {^(taps & G_ODD), ^(taps & G_EVEN)};
  endfunction

  function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] diff;
    diff = a ^ b;
    return {1'b0, diff[1]} + {1'b0, diff[0]};
  endfunction

endpackage

// File: rtl/viterbi_acs4.sv
// Combinational add-compare-select for the 4-state trellis: one stage of
// new path metrics plus one survivor bit per destination state.
module viterbi_acs4
  import viterbi_pkg::*;
#(
  parameter int PM_W = PM_W_DEF
) (
  input  logic [3:0][PM_W-1:0] pm_i,
  input  logic [1:0]           sym_i,
  output logic [3:0][PM_W-1:0] pm_o,
  output logic [3:0]           surv_o
);

  // Destination n = {u, s1} is reached from {n[0], 0} and {n[0], 1}.
  for (genvar n = 0; n < 4; n++) begin : g_state
    localparam int   P_LO = 2 * (n % 2);
    localparam int   P_HI = P_LO + 1;
    localparam logic U    = (n / 2) == 1;

    logic [PM_W-1:0] m_lo;
    logic [PM_W-1:0] m_hi;

    assign m_lo = pm_i[P_LO] + PM_W'(hamming2(branch_out(U, 2'(P_LO)), sym_i));
    assign m_hi = pm_i[P_HI] + PM_W'(hamming2(branch_out(U, 2'(P_HI)), sym_i));

    // Strict compare: equal metrics keep the lower predecessor, survivor 0.
    assign surv_o[n] = (m_hi < m_lo);
    assign pm_o[n]   = surv_o[n] ? m_hi : m_lo;
  end

endmodule

// File: rtl/viterbi_frame_ctrl.sv
// Frame controller: accepts NSYM received pairs, runs one ACS stage per
// cycle, traces back one stage per cycle and presents the decoded bits.
module viterbi_frame_ctrl
  import viterbi_pkg::*;
#(
  parameter int NSYM    = NSYM_DEF,
  parameter int PM_W    = PM_W_DEF,
  parameter int PM_INIT = PM_INIT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2*NSYM-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [NSYM-1:0]     out_data,
  output logic [PM_W-1:0]     out_metric,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy
);

  localparam int CNT_W = (NSYM > 1) ? $clog2(NSYM) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NSYM - 1);

  state_e                  state_q;
  logic                    in_ready_q;
  logic [2*NSYM-1:0]       frame_q;
  logic [3:0][PM_W-1:0]    pm_q;
  logic [NSYM-1:0][3:0]    surv_q;
  logic [CNT_W-1:0]        step_q;
  logic [1:0]              tb_state_q;
  logic [NSYM-1:0]         out_data_q;
  logic [PM_W-1:0]         out_metric_q;
  logic                    out_valid_q;

  logic [1:0]              sym;
  logic [3:0][PM_W-1:0]    pm_d;
  logic [3:0]              surv_d;
  logic [1:0]              best_state;
  logic [PM_W-1:0]         best_metric;

  viterbi_acs4 #(.PM_W(PM_W)) u_acs (
    .pm_i   (pm_q),
    .sym_i  (sym),
    .pm_o   (pm_d),
    .surv_o (surv_d)
  );

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned and infers a latch.
    sym         = '0;
    best_state  = '0;
    best_metric = pm_d[0];
    for (int i = 0; i < NSYM; i++) begin
      if (step_q == CNT_W'(i)) sym = frame_q[2*i +: 2];
    end
    // Strict compare keeps the lowest-indexed state on a tie.
    for (int k = 1; k < 4; k++) begin
      if (pm_d[k] < best_metric) begin
        best_state  = 2'(k);
        best_metric = pm_d[k];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      in_ready_q   <= 1'b0;
      frame_q      <= '0;
      pm_q         <= '0;
      // NOTE: the survivor store is only NSYM x 4 flops, not a RAM, so it is
      // cleared with everything else rather than left uninitialised.
      surv_q       <= '0;
      step_q       <= '0;
      tb_state_q   <= '0;
      out_data_q   <= '0;
      out_metric_q <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            in_ready_q <= 1'b0;
            frame_q    <= in_data;
            pm_q       <= {{3{PM_W'(PM_INIT)}}, {PM_W{1'b0}}};
            step_q     <= '0;
            state_q    <= ST_ACS;
          end
        end
        ST_ACS: begin
          pm_q           <= pm_d;
          surv_q[step_q] <= surv_d;
          if (step_q == LAST_STEP) begin
            out_metric_q <= best_metric;
            tb_state_q   <= best_state;
            state_q      <= ST_TB;
          end else begin
            step_q <= step_q + 1'b1;
          end
        end
        ST_TB: begin
          // The decoded bit is s1 of the state reached after this stage.
          out_data_q[step_q] <= tb_state_q[1];
          tb_state_q         <= {tb_state_q[0], surv_q[step_q][tb_state_q]};
          if (step_q == '0) begin
            out_valid_q <= 1'b1;
            state_q     <= ST_OUT;
          end else begin
            step_q <= step_q - 1'b1;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_data   = out_data_q;
  assign out_metric = out_metric_q;
  assign out_valid  = out_valid_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Directed bench for viterbi_frame_ctrl at default parameters: reset,
// clean and corrupted frames, back-pressure, mid-frame reset, back-to-back.
module tb_viterbi_frame_ctrl;

  localparam int LAT = 9;  // 1 + 2*NSYM at NSYM = 4

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] out_data;
  logic [4:0] out_metric;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  viterbi_frame_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_metric (out_metric),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  // Offers a frame from a negedge, returns cycles waited for in_ready and the
  // cycle count from handshake to out_valid (-1 on any timeout).
  task automatic send_frame(input logic [7:0] d, output int wait_cyc, output int lat);
    in_data  = d;
    in_valid = 1'b1;
    wait_cyc = 0;
    lat      = -1;
    while (in_ready !== 1'b1 && wait_cyc < 40) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (in_ready !== 1'b1) begin
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (out_valid !== 1'b1) lat = -1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (out_data !== 4'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    n_checks++; if (out_metric !== 5'd0) begin n_fail++; $display("FAIL reset_out_metric: got %0d want 0", out_metric); end
    rst_n = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL release_in_ready_early: got %b want 0", in_ready); end
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_zero_frame;
    int w, lat;
    out_ready = 1'b1;
    send_frame(8'h00, w, lat);
    n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL zero_latency: got %0d want %0d", lat, LAT); end
    n_checks++; if (out_data !== 4'b0000) begin n_fail++; $display("FAIL zero_data: got %b want 0000", out_data); end
    n_checks++; if (out_metric !== 5'd0) begin n_fail++; $display("FAIL zero_metric: got %0d want 0", out_metric); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL zero_valid_drop: got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL zero_back_idle: got %b want 1", in_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy_idle: got %b want 0", busy); end
  endtask

  task automatic test_clean_frame;
    int w, lat;
    out_ready = 1'b1;
    send_frame(8'h17, w, lat);
    n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL clean_latency: got %0d want %0d", lat, LAT); end
    n_checks++; if (out_data !== 4'b1011) begin n_fail++; $display("FAIL clean_data: got %b want 1011", out_data); end
    n_checks++; if (out_metric !== 5'd0) begin n_fail++; $display("FAIL clean_metric: got %0d want 0", out_metric); end
    @(negedge clk);
  endtask

  task automatic test_single_error;
    int w, lat;
    out_ready = 1'b1;
    send_frame(8'h16, w, lat);
    n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL err_latency: got %0d want %0d", lat, LAT); end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL err_valid: got %b want 1", out_valid); end
    n_checks++; if (out_metric !== 5'd1) begin n_fail++; $display("FAIL err_metric: got %0d want 1", out_metric); end
    n_checks++; if (out_data !== 4'b1011) begin n_fail++; $display("FAIL err_data: got %b want 1011", out_data); end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int w, lat;
    out_ready = 1'b0;
    send_frame(8'h17, w, lat);
    n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL bp_latency: got %0d want %0d", lat, LAT); end
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = 8'h00;
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want 1", k, out_valid); end
      n_checks++; if (out_data !== 4'b1011) begin n_fail++; $display("FAIL bp_data[%0d]: got %b want 1011", k, out_data); end
      n_checks++; if (out_metric !== 5'd0) begin n_fail++; $display("FAIL bp_metric[%0d]: got %0d want 0", k, out_metric); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_busy[%0d]: got %b want 1", k, busy); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0", k, in_ready); end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_release_busy: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_acs;
    int w, lat, seen;
    out_ready = 1'b1;
    in_data   = 8'h17;
    in_valid  = 1'b1;
    w = 0;
    while (in_ready !== 1'b1 && w < 40) begin @(negedge clk); w++; end
    @(negedge clk);          // first ACS cycle
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);          // ACS step 2
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_in_ready: got %b want 0", in_ready); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL rst_mid_no_output: got %0d valid cycles want 0", seen); end
    send_frame(8'h17, w, lat);
    n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL rst_mid_next_latency: got %0d want %0d", lat, LAT); end
    n_checks++; if (out_data !== 4'b1011) begin n_fail++; $display("FAIL rst_mid_next_data: got %b want 1011", out_data); end
    n_checks++; if (out_metric !== 5'd0) begin n_fail++; $display("FAIL rst_mid_next_metric: got %0d want 0", out_metric); end
  endtask

  task automatic test_back_to_back;
    int w, lat;
    out_ready = 1'b1;
    @(negedge clk);
    send_frame(8'h16, w, lat);
    n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL b2b_first_latency: got %0d want %0d", lat, LAT); end
    n_checks++; if (out_data !== 4'b1011) begin n_fail++; $display("FAIL b2b_first_data: got %b want 1011", out_data); end
    n_checks++; if (out_metric !== 5'd1) begin n_fail++; $display("FAIL b2b_first_metric: got %0d want 1", out_metric); end
    // Offered while the first result is being consumed.
    send_frame(8'h00, w, lat);
    n_checks++; if (w !== 1) begin n_fail++; $display("FAIL b2b_accept_wait: got %0d want 1", w); end
    n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL b2b_second_latency: got %0d want %0d", lat, LAT); end
    n_checks++; if (out_data !== 4'b0000) begin n_fail++; $display("FAIL b2b_second_data: got %b want 0000", out_data); end
    n_checks++; if (out_metric !== 5'd0) begin n_fail++; $display("FAIL b2b_second_metric: got %0d want 0", out_metric); end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    test_reset();
    test_zero_frame();
    test_clean_frame();
    test_single_error();
    test_backpressure();
    test_reset_mid_acs();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
